// File: rtl/measure_freq_multi.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : measure_freq_multi                                           |
// | Description : Multi-channel frequency meter. Each channel synchronises an  |
// |               asynchronous pre-divided clock and counts its rising edges   |
// |               over a selectable gate window (1 ms .. 1 s of reference     |
// |               clock). Results carry min/max history, clock-lost and        |
// |               overflow flags, and a common one-cycle valid strobe.         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module measure_freq_multi #(
    parameter int NUM_CH      = 4,
    parameter int C_REF_FREQ  = 100000000,
    parameter int CNT_W       = 24,
    parameter int SYNC_STAGES = 3
) (
    input  logic                    i_ref_clk,
    input  logic                    i_rst_n,
    input  logic [NUM_CH-1:0]       i_meas_div,
    input  logic                    i_enable,
    input  logic [1:0]              i_gate_sel,
    input  logic                    i_clr_minmax,
    output logic [NUM_CH*CNT_W-1:0] o_meas_cnt,
    output logic [NUM_CH*CNT_W-1:0] o_meas_min,
    output logic [NUM_CH*CNT_W-1:0] o_meas_max,
    output logic [NUM_CH-1:0]       o_clk_lost,
    output logic [NUM_CH-1:0]       o_overflow,
    output logic                    o_valid
);

    // Reference cycles per millisecond, and the last gate-counter value for
    // each of the four window lengths (N-1).
    localparam longint          c_base     = longint'(C_REF_FREQ) / 64'sd1000;
    localparam logic [31:0]     c_last_1ms = 32'(c_base - 64'sd1);
    localparam logic [31:0]     c_last_10  = 32'(c_base * 64'sd10 - 64'sd1);
    localparam logic [31:0]     c_last_100 = 32'(c_base * 64'sd100 - 64'sd1);
    localparam logic [31:0]     c_last_1s  = 32'(c_base * 64'sd1000 - 64'sd1);
    localparam logic [CNT_W-1:0] c_cnt_max = '1;

    logic [31:0] r_gate_cnt;
    logic [1:0]  r_sel;
    logic        r_armed;
    logic        r_valid;
    logic        r_first;

    logic [1:0]  w_sel_cur;
    logic [31:0] w_last;
    logic        w_run;
    logic        w_term;
    logic        w_load_first;

    // A window starts whenever the gate counter sits at 0, so the select
    // input seen on that cycle defines the whole window; afterwards the
    // latched copy is used and mid-window changes wait for the next start.
    assign w_sel_cur = (r_gate_cnt == 32'd0) ? i_gate_sel : r_sel;

    // Map the active select onto the terminal gate-counter value
    always_comb begin
        w_last = c_last_1ms;
        case (w_sel_cur)
            2'd0:    w_last = c_last_1ms;
            2'd1:    w_last = c_last_10;
            2'd2:    w_last = c_last_100;
            default: w_last = c_last_1s;
        endcase
    end

    // r_armed gives one idle cycle after reset release in which the window
    // select is captured, so counting only starts the cycle after.
    assign w_run        = i_enable & r_armed;
    assign w_term       = w_run & (r_gate_cnt == w_last);
    // A clear landing on the terminal cycle makes this result the first one
    assign w_load_first = r_first | i_clr_minmax;

    // Gate counter, latched select and registered result strobe
    always_ff @(posedge i_ref_clk) begin
        if (!i_rst_n) begin
            r_gate_cnt <= 32'd0;
            r_sel      <= 2'd0;
            r_armed    <= 1'b0;
            r_valid    <= 1'b0;
        end else begin
            r_armed <= 1'b1;
            r_valid <= w_term;
            r_sel   <= w_sel_cur;
            if (!w_run || w_term) begin
                r_gate_cnt <= 32'd0;
            end else begin
                r_gate_cnt <= r_gate_cnt + 32'd1;
            end
        end
    end

    // Min/max history flag: set by reset or clear, consumed by a result
    always_ff @(posedge i_ref_clk) begin
        if (!i_rst_n) begin
            r_first <= 1'b1;
        end else if (w_term) begin
            r_first <= 1'b0;
        end else if (i_clr_minmax) begin
            r_first <= 1'b1;
        end
    end

    assign o_valid = r_valid;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        logic [SYNC_STAGES-1:0] r_sync;
        logic [CNT_W-1:0]       r_edge_cnt;
        logic                   r_sticky;
        logic [CNT_W-1:0]       r_res;
        logic [CNT_W-1:0]       r_min;
        logic [CNT_W-1:0]       r_max;
        logic                   r_lost;
        logic                   r_ovf;

        logic                   w_rise;
        logic                   w_sat;
        logic [CNT_W-1:0]       w_next;

        // Rising edge detected between the last two synchroniser stages
        assign w_rise = r_sync[SYNC_STAGES-2] & ~r_sync[SYNC_STAGES-1];
        // Saturation means an edge arrived with the counter already full,
        // i.e. the reported count is no longer exact.
        assign w_sat  = w_rise & (r_edge_cnt == c_cnt_max);
        assign w_next = w_sat ? c_cnt_max
                              : r_edge_cnt + {{(CNT_W-1){1'b0}}, w_rise};

        // Shift the asynchronous divided clock through the synchroniser
        always_ff @(posedge i_ref_clk) begin
            if (!i_rst_n) begin
                r_sync <= '0;
            end else begin
                r_sync <= {r_sync[SYNC_STAGES-2:0], i_meas_div[k]};
            end
        end

        // Per-window edge counter with sticky overflow; restarts each window
        always_ff @(posedge i_ref_clk) begin
            if (!i_rst_n || !w_run || w_term) begin
                r_edge_cnt <= '0;
                r_sticky   <= 1'b0;
            end else begin
                r_edge_cnt <= w_next;
                if (w_sat) begin
                    r_sticky <= 1'b1;
                end
            end
        end

        // Capture the closing window's result and update min/max history
        always_ff @(posedge i_ref_clk) begin
            if (!i_rst_n) begin
                r_res  <= '0;
                r_min  <= '0;
                r_max  <= '0;
                r_lost <= 1'b0;
                r_ovf  <= 1'b0;
            end else if (w_term) begin
                r_res  <= w_next;
                r_ovf  <= r_sticky | w_sat;
                r_lost <= (w_next == '0);
                if (w_load_first) begin
                    r_min <= w_next;
                    r_max <= w_next;
                end else begin
                    if (w_next < r_min) begin
                        r_min <= w_next;
                    end
                    if (w_next > r_max) begin
                        r_max <= w_next;
                    end
                end
            end
        end

        assign o_meas_cnt[k*CNT_W +: CNT_W] = r_res;
        assign o_meas_min[k*CNT_W +: CNT_W] = r_min;
        assign o_meas_max[k*CNT_W +: CNT_W] = r_max;
        assign o_clk_lost[k]                = r_lost;
        assign o_overflow[k]                = r_ovf;
    end

endmodule
`default_nettype wire
